// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority share of one single-port SRAM among loader, data port and fetch, with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int AW       = 11,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          ld_req_i,
  input  logic          ld_lock_i,
  input  logic          ld_wen_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [3:0]    ld_wmask_i,
  input  logic [31:0]   ld_wdata_i,
  input  logic          dm_req_i,
  input  logic          dm_wen_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [3:0]    dm_wmask_i,
  input  logic [31:0]   dm_wdata_i,
  input  logic          im_req_i,
  input  logic [AW-1:0] im_addr_i,
  output logic          ld_gnt_o,
  output logic          dm_gnt_o,
  output logic          im_gnt_o,
  output logic          ld_rvalid_o,
  output logic          dm_rvalid_o,
  output logic          im_rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          core_stall_o,
  output logic          mem_csb_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_wmask_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t     state;
  logic [3:0] wait_cnt;
  logic       locked, im_starved;
  // Grants are gated by reset so the memory stays deselected while reset is held.
  always_comb begin
    locked       = (state == LOCKED) && ld_lock_i;
    im_starved   = !locked && im_req_i && (wait_cnt == 4'(MAX_WAIT));
    ld_gnt_o     = reset_i && ld_req_i;
    dm_gnt_o     = reset_i && !locked && !ld_req_i && !im_starved && dm_req_i;
    im_gnt_o     = reset_i && !locked && !ld_req_i && !dm_gnt_o && im_req_i;
    mem_csb_o    = !(ld_gnt_o || dm_gnt_o || im_gnt_o);
    mem_wen_o    = ld_gnt_o ? ld_wen_i : dm_gnt_o ? dm_wen_i : 1'b1;
    mem_addr_o   = ld_gnt_o ? ld_addr_i : dm_gnt_o ? dm_addr_i : im_gnt_o ? im_addr_i : '0;
    mem_wmask_o  = ld_gnt_o ? ld_wmask_i : dm_gnt_o ? dm_wmask_i : 4'b0000;
    mem_wdata_o  = ld_gnt_o ? ld_wdata_i : dm_gnt_o ? dm_wdata_i : 32'h0;
    core_stall_o = (dm_req_i && !dm_gnt_o) || (im_req_i && !im_gnt_o);
    rdata_o      = mem_rdata_i;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      ld_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      im_rvalid_o <= 1'b0;
    end else begin
      state       <= (locked || (ld_gnt_o && ld_lock_i)) ? LOCKED : IDLE;
      wait_cnt    <= (im_req_i && !im_gnt_o) ? ((wait_cnt == 4'(MAX_WAIT)) ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
      ld_rvalid_o <= ld_gnt_o && ld_wen_i;
      dm_rvalid_o <= dm_gnt_o && dm_wen_i;
      im_rvalid_o <= im_gnt_o;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant priority, locking, starvation, rvalid timing and reset.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  logic          clk_i = 1'b0, reset_i;
  logic          ld_req_i, ld_lock_i, ld_wen_i, dm_req_i, dm_wen_i, im_req_i;
  logic [AW-1:0] ld_addr_i, dm_addr_i, im_addr_i;
  logic [3:0]    ld_wmask_i, dm_wmask_i;
  logic [31:0]   ld_wdata_i, dm_wdata_i;
  logic          ld_gnt_o, dm_gnt_o, im_gnt_o, ld_rvalid_o, dm_rvalid_o, im_rvalid_o;
  logic [31:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic          core_stall_o, mem_csb_o, mem_wen_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_wmask_o;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            tests = 0, fails = 0;

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ld_req_i(ld_req_i), .ld_lock_i(ld_lock_i), .ld_wen_i(ld_wen_i), .ld_addr_i(ld_addr_i),
    .ld_wmask_i(ld_wmask_i), .ld_wdata_i(ld_wdata_i),
    .dm_req_i(dm_req_i), .dm_wen_i(dm_wen_i), .dm_addr_i(dm_addr_i),
    .dm_wmask_i(dm_wmask_i), .dm_wdata_i(dm_wdata_i),
    .im_req_i(im_req_i), .im_addr_i(im_addr_i),
    .ld_gnt_o(ld_gnt_o), .dm_gnt_o(dm_gnt_o), .im_gnt_o(im_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .dm_rvalid_o(dm_rvalid_o), .im_rvalid_o(im_rvalid_o),
    .rdata_o(rdata_o), .core_stall_o(core_stall_o),
    .mem_csb_o(mem_csb_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port SRAM with one-cycle registered read.
  always @(posedge clk_i) begin
    if (!mem_csb_o) begin
      if (!mem_wen_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs;
    ld_req_i = 0; ld_lock_i = 0; ld_wen_i = 1; ld_addr_i = '0; ld_wmask_i = '0; ld_wdata_i = '0;
    dm_req_i = 0; dm_wen_i = 1; dm_addr_i = '0; dm_wmask_i = '0; dm_wdata_i = '0;
    im_req_i = 0; im_addr_i = '0;
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = 32'h0;
    mem[11'h010] = 32'hCAFE_0010;
    mem[11'h020] = 32'hAAAA_AAAA;
    mem_rdata_i = 32'h0;
    reset_i = 0;
    idle_inputs();
    im_req_i = 1; im_addr_i = 11'h010;
    #3;
    chk("rst_im_gnt", im_gnt_o, 0);
    chk("rst_csb", mem_csb_o, 1);
    chk("rst_wen", mem_wen_o, 1);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wmask", mem_wmask_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rvalid", {ld_rvalid_o, dm_rvalid_o, im_rvalid_o}, 0);
    tick();
    reset_i = 1;
    // Fetch alone: granted, read issued, data one cycle later.
    #1;
    chk("t1_im_gnt", im_gnt_o, 1);
    chk("t1_csb", mem_csb_o, 0);
    chk("t1_wen", mem_wen_o, 1);
    chk("t1_addr", mem_addr_o, 32'h010);
    chk("t1_wmask", mem_wmask_o, 0);
    chk("t1_stall", core_stall_o, 0);
    tick();
    chk("t1_im_rvalid", im_rvalid_o, 1);
    chk("t1_rdata", rdata_o, 32'hCAFE_0010);
    // Data write beats fetch; no rvalid for a write.
    im_addr_i = 11'h011;
    dm_req_i = 1; dm_wen_i = 0; dm_addr_i = 11'h020; dm_wmask_i = 4'b0011; dm_wdata_i = 32'h1234_5678;
    #1;
    chk("t2_dm_gnt", dm_gnt_o, 1);
    chk("t2_im_gnt", im_gnt_o, 0);
    chk("t2_stall", core_stall_o, 1);
    chk("t2_wen", mem_wen_o, 0);
    chk("t2_addr", mem_addr_o, 32'h020);
    chk("t2_wmask", mem_wmask_o, 4'b0011);
    chk("t2_wdata", mem_wdata_o, 32'h1234_5678);
    tick();
    chk("t2_rvalid", {ld_rvalid_o, dm_rvalid_o, im_rvalid_o}, 0);
    // Nothing requested.
    idle_inputs();
    #1;
    chk("t6_gnt", {ld_gnt_o, dm_gnt_o, im_gnt_o}, 0);
    chk("t6_csb", mem_csb_o, 1);
    chk("t6_wen", mem_wen_o, 1);
    chk("t6_stall", core_stall_o, 0);
    tick();
    // dm and im both held: dm x4, im once, then dm again; read back masked write.
    dm_req_i = 1; dm_wen_i = 1; dm_addr_i = 11'h020;
    im_req_i = 1; im_addr_i = 11'h010;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_dm_gnt", dm_gnt_o, i != 4);
      chk("t3_im_gnt", im_gnt_o, i == 4);
      tick();
      chk("t3_dm_rvalid", dm_rvalid_o, i != 4);
      chk("t3_im_rvalid", im_rvalid_o, i == 4);
      chk("t3_rdata", rdata_o, (i == 4) ? 32'hCAFE_0010 : 32'hAAAA_5678);
    end
    // Loader lock excludes dm/im, even while ld is idle; dropping lock frees dm immediately.
    im_req_i = 0;
    ld_req_i = 1; ld_lock_i = 1; ld_wen_i = 1; ld_addr_i = 11'h010;
    #1;
    chk("t4a_ld_gnt", ld_gnt_o, 1);
    chk("t4a_dm_gnt", dm_gnt_o, 0);
    chk("t4a_stall", core_stall_o, 1);
    chk("t4a_addr", mem_addr_o, 32'h010);
    tick();
    chk("t4a_ld_rvalid", ld_rvalid_o, 1);
    chk("t4a_rdata", rdata_o, 32'hCAFE_0010);
    chk("t4a_dm_rvalid", dm_rvalid_o, 0);
    #1;
    chk("t4b_ld_gnt", ld_gnt_o, 1);
    chk("t4b_dm_gnt", dm_gnt_o, 0);
    tick();
    ld_req_i = 0; im_req_i = 1;
    #1;
    chk("t4c_gnt", {ld_gnt_o, dm_gnt_o, im_gnt_o}, 0);
    chk("t4c_csb", mem_csb_o, 1);
    chk("t4c_stall", core_stall_o, 1);
    tick();
    chk("t4c_ld_rvalid", ld_rvalid_o, 0);
    ld_lock_i = 0;
    #1;
    chk("t4d_dm_gnt", dm_gnt_o, 1);
    chk("t4d_im_gnt", im_gnt_o, 0);
    tick();
    chk("t4d_dm_rvalid", dm_rvalid_o, 1);
    chk("t4d_rdata", rdata_o, 32'hAAAA_5678);
    // Reset during a dm read grant drops its rvalid.
    idle_inputs();
    dm_req_i = 1; dm_wen_i = 1; dm_addr_i = 11'h020;
    #1;
    chk("t5_dm_gnt", dm_gnt_o, 1);
    reset_i = 0;
    #1;
    chk("t5_rst_dm_gnt", dm_gnt_o, 0);
    chk("t5_rst_csb", mem_csb_o, 1);
    tick();
    chk("t5_dm_rvalid", dm_rvalid_o, 0);
    reset_i = 1;
    // Reset aborts LOCKED asynchronously and clears a pending rvalid at once.
    idle_inputs();
    ld_req_i = 1; ld_lock_i = 1; ld_wen_i = 1; ld_addr_i = 11'h010;
    #1;
    chk("t5b_ld_gnt", ld_gnt_o, 1);
    tick();
    chk("t5b_ld_rvalid", ld_rvalid_o, 1);
    reset_i = 0;
    #1;
    chk("t5b_async_rvalid", ld_rvalid_o, 0);
    tick();
    reset_i = 1;
    ld_req_i = 0; dm_req_i = 1; dm_wen_i = 1; dm_addr_i = 11'h020;
    #1;
    chk("t5b_idle_dm_gnt", dm_gnt_o, 1);
    tick();
    chk("t5b_dm_rvalid", dm_rvalid_o, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
